visualizador_periodo: RTL

Downstream display stage for the period measurement. It samples the 12-bit `valor_periodo` produced by `calculador_periodo` and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a 4-digit, common-anode, multiplexed seven-segment display with leading-zero blanking. All logic runs on the board clock.

---
 rtl/visualizador_periodo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/visualizador_periodo.sv
// Period display stage: binary-to-BCD conversion by sequential
// double-dabble and a multiplexed 4-digit seven-segment driver.
module visualizador_periodo #(
   parameter int DIV_REFRESCO = 50000
) (
   input  logic        reloj_placa,
   input  logic        reinicio_n,
   input  logic [11:0] valor_periodo,
   output logic [15:0] bcd,
   output logic        listo,
   output logic [3:0]  anodos,
   output logic [6:0]  segmentos,
   output logic        punto
);

   typedef enum logic [1:0] {
      REPOSO,
      DESPLAZA,
      ACTUALIZA
   } estado_t;

   localparam int AW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
   localparam logic [AW-1:0] TOPE = AW'(DIV_REFRESCO - 1);

   estado_t     estado;
   estado_t     estado_sig;
   logic [11:0] ultimo;
   logic [27:0] desp;
   logic [27:0] corregido;
   logic [3:0]  cuenta;
   logic        hay_cambio;

   logic [AW-1:0] refresco;
   logic [1:0]    indice;
   logic [3:0]    nibble;
   logic          apagado;

   assign punto      = 1'b1;
   assign hay_cambio = (valor_periodo != ultimo);

   // Every BCD nibble (units up to thousands) gets its add-3 fix before the shift
   always_comb begin
      corregido = desp;
      for (int k = 0; k < 4; k++) begin
         if (desp[12+4*k +: 4] >= 4'd5)
            corregido[12+4*k +: 4] = desp[12+4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge reloj_placa or negedge reinicio_n) begin
      if (!reinicio_n)
         estado <= REPOSO;
      else
         estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      unique case (estado)
         REPOSO:    if (hay_cambio) estado_sig = DESPLAZA;
         DESPLAZA:  if (cuenta == 4'd11) estado_sig = ACTUALIZA;
         ACTUALIZA: estado_sig = REPOSO;
         default:   estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge reloj_placa or negedge reinicio_n) begin
      if (!reinicio_n) begin
         ultimo <= '0;
         desp   <= '0;
         cuenta <= '0;
         bcd    <= '0;
         listo  <= 1'b0;
      end else begin
         listo <= 1'b0;
         unique case (estado)
            REPOSO: begin
               if (hay_cambio) begin
                  ultimo <= valor_periodo;
                  desp   <= {16'b0, valor_periodo};
                  cuenta <= '0;
               end
            end
            DESPLAZA: begin
               desp   <= corregido << 1;
               cuenta <= cuenta + 4'd1;
            end
            ACTUALIZA: begin
               bcd   <= desp[27:12];
               listo <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge reloj_placa or negedge reinicio_n) begin
      if (!reinicio_n) begin
         refresco <= '0;
         indice   <= '0;
      end else if (refresco == TOPE) begin
         refresco <= '0;
         indice   <= indice + 2'd1;
      end else begin
         refresco <= refresco + 1'b1;
      end
   end

   function automatic logic [6:0] decodifica(input logic [3:0] n);
      case (n)
         4'd0:    decodifica = 7'b1000000;
         4'd1:    decodifica = 7'b1111001;
         4'd2:    decodifica = 7'b0100100;
         4'd3:    decodifica = 7'b0110000;
         4'd4:    decodifica = 7'b0011001;
         4'd5:    decodifica = 7'b0010010;
         4'd6:    decodifica = 7'b0000010;
         4'd7:    decodifica = 7'b1111000;
         4'd8:    decodifica = 7'b0000000;
         4'd9:    decodifica = 7'b0010000;
         default: decodifica = 7'b1111111;
      endcase
   endfunction

   assign nibble = bcd[{indice, 2'b00} +: 4];

   // Units digit stays lit so a zero value still shows "0"
   always_comb begin
      apagado = 1'b0;
      unique case (indice)
         2'd0: apagado = 1'b0;
         2'd1: apagado = (bcd[15:4] == 12'd0);
         2'd2: apagado = (bcd[15:8] == 8'd0);
         2'd3: apagado = (bcd[15:12] == 4'd0);
         default: apagado = 1'b0;
      endcase
   end

   always_ff @(posedge reloj_placa or negedge reinicio_n) begin
      if (!reinicio_n) begin
         anodos    <= 4'b1111;
         segmentos <= 7'b1111111;
      end else if (apagado) begin
         anodos    <= 4'b1111;
         segmentos <= 7'b1111111;
      end else begin
         anodos    <= ~(4'b0001 << indice);
         segmentos <= decodifica(nibble);
      end
   end

endmodule
